// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode, field-position and fetch-state definitions shared by fetch and control.
package fetch_pkg;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'd0,
        OP_LDR   = 5'd1,
        OP_STR   = 5'd2,
        OP_BEQ   = 5'd3,
        OP_ADDI  = 5'd4
    } opcode_e;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } fetch_state_e;

    localparam int OPCODE_LSB = 27;
    localparam int ALUOP_LSB  = 24;
    localparam int RD_LSB     = 20;
    localparam int RN_LSB     = 16;
    localparam int RM_LSB     = 12;
    localparam int IMM_LSB    = 0;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  aluop;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [15:0] imm;
    } instr_fields_t;

    function automatic logic opcode_legal(input logic [4:0] op);
        return op inside {OP_RTYPE, OP_LDR, OP_STR, OP_BEQ, OP_ADDI};
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// instr_field_split: splits a 32-bit instruction word into decode fields and flags known opcodes.
module instr_field_split
    import fetch_pkg::*;
(
    input  logic [31:0]   word,
    output instr_fields_t fields,
    output logic          legal
);

    always_comb begin
        fields.opcode = word[OPCODE_LSB +: 5];
        fields.aluop  = word[ALUOP_LSB +: 3];
        fields.rd     = word[RD_LSB +: 4];
        fields.rn     = word[RN_LSB +: 4];
        fields.rm     = word[RM_LSB +: 4];
        fields.imm    = word[IMM_LSB +: 16];
        legal         = opcode_legal(fields.opcode);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, single-outstanding imem fetch FSM, branch redirect and decode handshake.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_opcode,
    output logic [2:0]        out_aluop,
    output logic [3:0]        out_rd,
    output logic [3:0]        out_rn,
    output logic [3:0]        out_rm,
    output logic [15:0]       out_imm,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              illegal
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, out_pc_q, out_pc_d, br_pc;
    instr_fields_t     fields_q, fields_d, rdata_fields;
    logic              drop_q, drop_d, illegal_q, illegal_d, rdata_legal;
    logic              unused_br_lsbs;

    instr_field_split u_split (
        .word   (imem_rdata),
        .fields (rdata_fields),
        .legal  (rdata_legal)
    );

    assign br_pc          = {br_target[ADDR_W-1:2], 2'b00};
    assign unused_br_lsbs = ^br_target[1:0];

    // addr_q is the address on the bus; pc_q may run ahead of it after a redirect
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        out_pc_d  = out_pc_q;
        fields_d  = fields_q;
        drop_d    = drop_q;
        illegal_d = illegal_q;
        case (state_q)
            S_REQ: begin
                if (br_taken) begin
                    pc_d   = br_pc;
                    drop_d = 1'b1;
                end
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (br_taken) begin
                    pc_d   = br_pc;
                    drop_d = 1'b1;
                end
                if (imem_rvalid) begin
                    if (drop_q || br_taken) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                        addr_d  = pc_d;
                    end else if (rdata_legal) begin
                        state_d  = S_HOLD;
                        fields_d = rdata_fields;
                        out_pc_d = addr_q;
                    end else begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                        fields_d  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (br_taken || out_ready) begin
                    pc_d    = br_taken ? br_pc : pc_q + ADDR_W'(4);
                    addr_d  = pc_d;
                    state_d = S_REQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            out_pc_q  <= RESET_PC;
            fields_q  <= '0;
            drop_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            out_pc_q  <= out_pc_d;
            fields_q  <= fields_d;
            drop_q    <= drop_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        imem_req   = (state_q == S_REQ) && !rst;
        imem_addr  = addr_q;
        out_valid  = state_q == S_HOLD;
        out_opcode = fields_q.opcode;
        out_aluop  = fields_q.aluop;
        out_rd     = fields_q.rd;
        out_rn     = fields_q.rn;
        out_rm     = fields_q.rm;
        out_imm    = fields_q.imm;
        out_pc     = out_pc_q;
        illegal    = illegal_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus a randomized memory/redirect run checked against a PC-level scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, out_ready = 1'b0, br_taken = 1'b0;
    logic [31:0] imem_rdata = '0, br_target = '0;

    logic        imem_req, out_valid, illegal;
    logic [31:0] imem_addr, out_pc;
    logic [4:0]  out_opcode;
    logic [2:0]  out_aluop;
    logic [3:0]  out_rd, out_rn, out_rm;
    logic [15:0] out_imm;

    logic        w_req, w_valid, w_illegal;
    logic [31:0] w_addr, w_pc;
    logic [4:0]  w_opcode;
    logic [2:0]  w_aluop;
    logic [3:0]  w_rd, w_rn, w_rm;
    logic [15:0] w_imm;

    logic [35:0] got_f;
    logic [31:0] mem [256];
    int          vectors = 0, errors = 0;

    assign got_f = {out_opcode, out_aluop, out_rd, out_rn, out_rm, out_imm};

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_aluop(out_aluop), .out_rd(out_rd), .out_rn(out_rn), .out_rm(out_rm),
        .out_imm(out_imm), .out_pc(out_pc), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(w_valid), .out_ready(out_ready),
        .out_opcode(w_opcode), .out_aluop(w_aluop), .out_rd(w_rd), .out_rn(w_rn), .out_rm(w_rm),
        .out_imm(w_imm), .out_pc(w_pc), .br_taken(br_taken), .br_target(br_target), .illegal(w_illegal)
    );

    function automatic logic [35:0] exp_fields(input logic [31:0] w);
        return {w[31:27], w[26:24], w[23:20], w[19:16], w[15:12], w[15:0]};
    endfunction

    function automatic logic [31:0] legal_word();
        logic [31:0] w = $urandom;
        w[31:27] = 5'($urandom_range(0, 4));
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0; br_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a request, grants it and returns the word the following cycle.
    task automatic fetch_word(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (imem_req) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) return;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = w;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0123_4567;
        repeat (2) @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: req=%b valid=%b illegal=%b want 0 0 0", imem_req, out_valid, illegal);
        end
        vectors++;
        if (imem_addr !== 32'h0 || out_pc !== 32'h0 || got_f !== 36'h0) begin
            errors++; $display("FAIL reset_data: addr=%h pc=%h fields=%h want 0 0 0", imem_addr, out_pc, got_f);
        end
        vectors++;
        if (w_addr !== 32'hFFFF_FFFC || w_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL reset_pc_param: addr=%h pc=%h want fffffffc", w_addr, w_pc);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; rst = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL reset_release_req: req=%b want 1", imem_req);
        end
    endtask

    task automatic test_first_fetch();
        bit ok;
        do_reset();
        #1;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        fetch_word(32'h0123_4000, ok);
        vectors++;
        if (!ok || out_valid !== 1'b1 || got_f !== {5'd0, 3'd1, 4'd2, 4'd3, 4'd4, 16'h4000} || out_pc !== 32'h0) begin
            errors++; $display("FAIL first_fields: ok=%b valid=%b fields=%h pc=%h", ok, out_valid, got_f, out_pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || out_valid !== 1'b0) begin
            errors++; $display("FAIL first_next_req: req=%b addr=%h valid=%b want 1 4 0", imem_req, imem_addr, out_valid);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] w = legal_word();
        do_reset();
        fetch_word(w, ok);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (!ok || out_valid !== 1'b1 || got_f !== exp_fields(w) || out_pc !== 32'h0) begin
                errors++; $display("FAIL stall_hold[%0d]: valid=%b fields=%h want %h pc=%h", i, out_valid, got_f, exp_fields(w), out_pc);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++; $display("FAIL stall_next_req: req=%b addr=%h want 1 4", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        logic [31:0] w = legal_word();
        do_reset();
        #1;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; br_taken = 1'b1; br_target = 32'h103;
        @(negedge clk);
        br_taken = 1'b0; imem_rvalid = 1'b1; imem_rdata = legal_word();
        @(negedge clk);
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                errors++; $display("FAIL redir_wait_drop[%0d]: valid=%b req=%b addr=%h want 0 1 100", i, out_valid, imem_req, imem_addr);
            end
            @(negedge clk);
        end
        fetch_word(w, ok);
        vectors++;
        if (!ok || out_valid !== 1'b1 || out_pc !== 32'h100 || got_f !== exp_fields(w)) begin
            errors++; $display("FAIL redir_wait_target: valid=%b pc=%h fields=%h want 100 %h", out_valid, out_pc, got_f, exp_fields(w));
        end
    endtask

    task automatic test_redirect_req();
        do_reset();
        #1;
        br_taken = 1'b1; br_target = 32'h2FE;
        @(negedge clk);
        br_taken = 1'b0;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL redir_req_stable: req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = legal_word();
        @(negedge clk);
        imem_rvalid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2FC) begin
            errors++; $display("FAIL redir_req_drop: valid=%b req=%b addr=%h want 0 1 2fc", out_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        logic [31:0] w = legal_word();
        do_reset();
        fetch_word(legal_word(), ok);
        out_ready = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        @(negedge clk);
        out_ready = 1'b0; br_taken = 1'b0;
        vectors++;
        if (!ok || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL redir_hold_ready: valid=%b req=%b addr=%h want 0 1 40", out_valid, imem_req, imem_addr);
        end
        fetch_word(w, ok);
        vectors++;
        if (!ok || out_valid !== 1'b1 || out_pc !== 32'h40 || got_f !== exp_fields(w)) begin
            errors++; $display("FAIL redir_hold_target: valid=%b pc=%h fields=%h want 40 %h", out_valid, out_pc, got_f, exp_fields(w));
        end
    endtask

    task automatic test_illegal();
        bit ok;
        logic [31:0] w = $urandom;
        w[31:27] = 5'b11111;
        do_reset();
        fetch_word(w, ok);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (!ok || illegal !== 1'b1 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
                errors++; $display("FAIL illegal_halt[%0d]: illegal=%b valid=%b req=%b want 1 0 0", i, illegal, out_valid, imem_req);
            end
            imem_gnt = 1'($urandom); imem_rvalid = 1'($urandom); imem_rdata = legal_word();
            out_ready = 1'($urandom); br_taken = 1'($urandom); br_target = $urandom;
            @(negedge clk);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0; br_taken = 1'b0; rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (illegal !== 1'b0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL illegal_clear: illegal=%b addr=%h want 0 0", illegal, imem_addr);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL illegal_restart: req=%b want 1", imem_req);
        end
    endtask

    task automatic test_back_to_back();
        bit pend = 1'b0;
        logic [31:0] a = '0;
        int n = 0;
        do_reset();
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) begin
                vectors++;
                if (out_pc !== 32'(4 * n) || got_f !== exp_fields(mem[(4 * n / 4) % 256])) begin
                    errors++; $display("FAIL b2b_pc[%0d]: pc=%h fields=%h want pc %h", n, out_pc, got_f, 32'(4 * n));
                end
                n++;
            end
            imem_rvalid = pend; imem_rdata = mem[a[9:2]];
            pend = imem_req; imem_gnt = imem_req; a = imem_addr;
            @(negedge clk);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (n != 10) begin
            errors++; $display("FAIL b2b_rate: %0d instructions in 30 cycles, want 10", n);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        #1;
        vectors++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first_req: req=%b addr=%h want 1 fffffffc", w_req, w_addr);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mem[255];
        @(negedge clk);
        imem_rvalid = 1'b0;
        vectors++;
        if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_present: valid=%b pc=%h want 1 fffffffc", w_valid, w_pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next_addr: req=%b addr=%h want 1 0", w_req, w_addr);
        end
    endtask

    // Scoreboard: the next presented instruction is at exp_pc, which advances by 4 on acceptance
    // or jumps to the aligned target on any redirect; its fields come straight from the memory image.
    task automatic test_random();
        bit pend = 1'b0, prev_req_wait = 1'b0, prev_hold = 1'b0;
        int cnt = 0, pres = 0;
        logic [31:0] pa = '0, exp_pc = '0, prev_addr = '0, prev_pc = '0;
        logic [35:0] prev_f = '0;
        do_reset();
        #1;
        for (int c = 0; c < 3000; c++) begin
            vectors++;
            if (pend && imem_req) begin
                errors++; $display("FAIL rnd_outstanding: cycle %0d req=%b while fetch pending", c, imem_req);
            end
            vectors++;
            if (prev_req_wait && (imem_req !== 1'b1 || imem_addr !== prev_addr)) begin
                errors++; $display("FAIL rnd_req_stable: cycle %0d req=%b addr=%h want 1 %h", c, imem_req, imem_addr, prev_addr);
            end
            vectors++;
            if (prev_hold && (out_valid !== 1'b1 || got_f !== prev_f || out_pc !== prev_pc)) begin
                errors++; $display("FAIL rnd_hold_stable: cycle %0d valid=%b fields=%h pc=%h want 1 %h %h", c, out_valid, got_f, out_pc, prev_f, prev_pc);
            end
            vectors++;
            if (illegal !== 1'b0) begin
                errors++; $display("FAIL rnd_illegal: cycle %0d illegal=%b want 0", c, illegal);
            end
            if (out_valid) begin
                vectors++;
                if (out_pc !== exp_pc || got_f !== exp_fields(mem[exp_pc[9:2]])) begin
                    errors++; $display("FAIL rnd_present: cycle %0d pc=%h fields=%h want %h %h", c, out_pc, got_f, exp_pc, exp_fields(mem[exp_pc[9:2]]));
                end
                pres++;
            end
            if (pend && cnt == 0) begin
                imem_rvalid = 1'b1; imem_rdata = mem[pa[9:2]]; pend = 1'b0;
            end else begin
                if (pend) cnt--;
                imem_rvalid = !pend && $urandom_range(0, 7) == 0;
                imem_rdata = 32'hFFFF_FFFF;
            end
            imem_gnt = imem_req && !pend && $urandom_range(0, 2) != 0;
            if (imem_gnt) begin
                pend = 1'b1; pa = imem_addr; cnt = $urandom_range(0, 2);
            end
            br_taken = $urandom_range(0, 15) == 0;
            br_target = $urandom & 32'h3FF;
            out_ready = 1'($urandom);
            prev_req_wait = imem_req && !imem_gnt; prev_addr = imem_addr;
            prev_hold = out_valid && !out_ready && !br_taken; prev_f = got_f; prev_pc = out_pc;
            if (br_taken) exp_pc = {br_target[31:2], 2'b00};
            else if (out_valid && out_ready) exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0; br_taken = 1'b0;
        vectors++;
        if (pres < 100) begin
            errors++; $display("FAIL rnd_progress: %0d instructions presented, want at least 100", pres);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = legal_word();
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_hold();
        test_illegal();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
